// File: rtl/spi_tx_sched.sv
// rtl/spi_tx_sched.sv - round-robin SPI transmit scheduler feeding the slave serializer
// Optional SPI_SCHED_PRIO_EN: fixed priority arbitration, req[0] highest.
module spi_tx_sched #(
   parameter int NREQ        = 4,
   parameter int DW          = 14,
   parameter int SYNC_STAGES = 2,
   localparam int GW         = $clog2(NREQ),
   localparam int CW         = $clog2(DW) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sck,
   input  logic             cs,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]  ack,
   output logic [DW-1:0]    p2s_data,
   output logic             head_flag,
   output logic [GW-1:0]    grant_id,
   output logic             busy,
   output logic             frame_done,
   output logic             frame_abort
);

   typedef enum logic [2:0] {S_IDLE, S_GRANT, S_LOAD, S_SHIFT, S_TAIL} state_t;

   state_t                 r_state, w_next;
   logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync;
   logic                   r_sck_d, r_cs_d;
   logic                   w_sck_fall, w_cs_fall, w_cs_rise;
   logic [GW-1:0]          r_last, r_grant_id, w_win;
   logic                   w_found;
   logic [DW-1:0]          r_p2s;
   logic [CW-1:0]          r_bit_cnt;
   logic [NREQ-1:0]        r_ack;
   logic                   r_done, r_abort;
   logic                   w_done_evt, w_abort_evt;

   function automatic logic [GW-1:0] search_idx(input logic [GW-1:0] last, input int k);
      int t;
`ifdef SPI_SCHED_PRIO_EN
      t = k - 1;
`else
      t = (int'(last) + k) % NREQ;
`endif
      return GW'(t);
   endfunction

   // cs synchronizer resets to the deselected level so reset release is not a cs_fall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sck_sync <= '0;
         r_cs_sync  <= '1;
         r_sck_d    <= 1'b0;
         r_cs_d     <= 1'b1;
      end else begin
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
         r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs};
         r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
         r_cs_d     <= r_cs_sync[SYNC_STAGES-1];
      end
   end

   assign w_sck_fall = r_sck_d & ~r_sck_sync[SYNC_STAGES-1];
   assign w_cs_fall  = r_cs_d & ~r_cs_sync[SYNC_STAGES-1];
   assign w_cs_rise  = ~r_cs_d & r_cs_sync[SYNC_STAGES-1];

   // Scan downward so the lowest search position that requests wins
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[search_idx(r_last, k)]) begin
            w_found = 1'b1;
            w_win   = search_idx(r_last, k);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_done_evt  = 1'b0;
      w_abort_evt = 1'b0;
      case (r_state)
         S_IDLE:  if (w_cs_fall) w_next = S_GRANT;
         S_GRANT: begin
            if (w_cs_rise) begin
               w_abort_evt = 1'b1;
               w_next      = S_IDLE;
            end else begin
               w_next = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_cs_rise) begin
               w_abort_evt = 1'b1;
               w_next      = S_IDLE;
            end else if (w_sck_fall) begin
               w_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_cs_rise) begin
               w_abort_evt = 1'b1;
               w_next      = S_IDLE;
            end else if (w_sck_fall && r_bit_cnt == CW'(DW-1)) begin
               w_done_evt = 1'b1;
               w_next     = S_TAIL;
            end
         end
         S_TAIL:  if (w_cs_rise) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p2s      <= '0;
         r_grant_id <= '0;
         r_last     <= GW'(NREQ-1);
         r_bit_cnt  <= '0;
         r_ack      <= '0;
         r_done     <= 1'b0;
         r_abort    <= 1'b0;
      end else begin
         r_ack   <= '0;
         r_done  <= w_done_evt;
         r_abort <= w_abort_evt;
         if (r_state == S_GRANT) begin
            if (w_found) begin
               r_p2s        <= req_data[int'(w_win)*DW +: DW];
               r_grant_id   <= w_win;
               r_last       <= w_win;
               r_ack[w_win] <= 1'b1;
            end else begin
               r_p2s <= '0;
            end
         end
         if (r_state == S_LOAD && w_sck_fall && !w_cs_rise)
            r_bit_cnt <= '0;
         else if (r_state == S_SHIFT && w_sck_fall && !w_cs_rise && r_bit_cnt < CW'(DW-1))
            r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   end

   assign ack         = r_ack;
   assign p2s_data    = (r_state == S_IDLE) ? '0 : r_p2s;
   assign head_flag   = (r_state == S_SHIFT);
   assign grant_id    = r_grant_id;
   assign busy        = (r_state != S_IDLE);
   assign frame_done  = r_done;
   assign frame_abort = r_abort;

endmodule

// File: doc/spi_tx_sched.md
# spi_tx_sched

Transmit scheduler for the SPI slave serializer. It shares the serializer between NREQ parallel data sources (ADC channels, status words) using round-robin arbitration. It sequences each SPI frame by driving the serializer's 14-bit parallel word and its head_flag load/shift control. It runs entirely in the system clock domain and oversamples the external sck and cs.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 14, word width; equals serializer width
- SYNC_STAGES, 2, flip-flop stages on sck and cs synchronizers (≥2)

Ports:
- clk  in  1  system clock; must be ≥8× sck frequency
- rst  in  1  asynchronous, active-high reset
- sck  in  1  SPI clock from master (async)
- cs  in  1  SPI chip select, active low (async)
- req  in  NREQ  per-requester word-valid, level; held until ack
- req_data  in  NREQ*DW  requester words, requester i at [i*DW +: DW]
- ack  out  NREQ  one-clk pulse to granted requester; word consumed
- p2s_data  out  DW  parallel word to serializer
- head_flag  out  1  serializer control: 0 = load on next sck falling edge, 1 = shift
- grant_id  out  clog2(NREQ)  index of requester owning the current frame
- busy  out  1  frame in progress (state ≠ IDLE)
- frame_done  out  1  one-clk pulse, all DW bits shifted out
- frame_abort  out  1  one-clk pulse, cs rose before frame completed

## Operation
- sck and cs pass through SYNC_STAGES synchronizers. Edge detectors run on the synchronized values: sck_fall and cs_fall / cs_rise.
- States: IDLE, GRANT, LOAD, SHIFT, TAIL.
- IDLE: head_flag=0, p2s_data=0. On cs_fall go to GRANT.
- GRANT (1 clk):
  - Pick the winner among asserted req, round-robin starting at last_grant+1 modulo NREQ.
  - Latch req_data of the winner into p2s_data and set grant_id.
  - Pulse ack[winner] and update last_grant. Go to LOAD.
  - If no req is asserted: p2s_data=0, no ack, grant_id and last_grant unchanged, go to LOAD. A zero word is transmitted.
- LOAD: head_flag=0. On sck_fall, the serializer has loaded the word; clear bit_cnt, set head_flag=1, go to SHIFT.
- SHIFT: head_flag=1. Each sck_fall increments bit_cnt. The sck_fall at bit_cnt==DW-1 pulses frame_done, drops head_flag to 0 and goes to TAIL.
- TAIL: head_flag=0, so the serializer output is 0. On cs_rise go to IDLE.
- cs_rise in GRANT, LOAD or SHIFT:
  - Pulse frame_abort and go to IDLE.
  - The word is not re-queued (ack was already given).
  - A cs_rise in TAIL is normal and produces no abort.
- cs_fall and cs_rise are only acted on in the states listed; a cs_fall outside IDLE is ignored.
- p2s_data holds its value from GRANT until the next GRANT. It is stable for the whole frame.
- Reset values:
  - state=IDLE, head_flag=0, p2s_data=0, ack=0, grant_id=0, busy=0, frame_done=0, frame_abort=0.
  - bit_cnt=0, last_grant=NREQ-1, so the first grant search starts at requester 0.
- Reset asserted mid-frame returns to IDLE immediately with all outputs at reset values. No done or abort pulse is produced.

## Timing
- Detection latency: SYNC_STAGES+1 clk from an external sck/cs edge to the state change.
- head_flag rises at most SYNC_STAGES+2 clk after the sck falling edge that loads the serializer. With clk ≥ 8× sck, this lands before the next sck falling edge.
- ack pulses exactly 1 clk, in the cycle after GRANT is entered. The requester may drop req or present a new word in the following cycle.
- A frame has DW+1 sck falling edges of interest: 1 load edge plus DW shift edges; the last one moves the block to TAIL.
- frame_done and frame_abort are mutually exclusive and never asserted in the same frame.
- bit_cnt width is clog2(DW)+1 and saturates; it never wraps within a frame.

## Configuration
- SPI_SCHED_PRIO_EN:
  - Defined: fixed priority, req[0] highest. last_grant is not used for the search but still updates grant_id.
  - Undefined (default): round-robin as described above.

## Test plan
- Single frame: req=4'b0010, req_data[1]=14'h2A5C, cs low, 15 sck cycles → ack=4'b0010 once; head_flag 0 until the first sck fall, then 1 for 14 falls; serializer output 14'h2A5C MSB-first; frame_done pulses once; then cs high → IDLE.
- Round-robin: req=4'b1111 held, 4 frames → grant_id sequence 0,1,2,3, then 0 on the fifth frame. With SPI_SCHED_PRIO_EN defined → 0,0,0,0.
- Empty frame: req=0, full frame → no ack, p2s_data=0, 14 zero bits transmitted, frame_done pulses, last_grant unchanged.
- Abort: cs rises after 6 shift edges → frame_abort pulses once, no frame_done, state IDLE, head_flag=0. The next cs_fall grants the next requester, not the aborted one.
- Reset mid-SHIFT: assert rst at bit_cnt=9 → all outputs 0 within the same clk; after release, the first grant goes to requester 0.
- Boundary: cs_fall while in TAIL (no cs_rise in between) → ignored, no new GRANT; a 1:8 clk:sck ratio is tested with no missed load/shift edge.
